ex_mem_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU; captures the ALU result, zero flag and the control and operand fields travelling with it.
- Presents them to the memory/writeback side through a 2-entry valid/ready skid buffer.
- Resolves conditional branches (BEQ/BNE) from the captured zero flag.
- Issues a flush request upstream on a taken branch.

---
 rtl/ex_mem_stage.sv | 153 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: pipeline stage after the ALU. It captures the ALU result,
// zero flag and the control/operand fields that travel with it. These are
// held in a 2-entry valid/ready skid buffer: head H and skid S. BEQ/BNE is
// resolved from the zero flag of H on its output handshake.
//
// Optional forwarding outputs are built only when EX_MEM_FWD_EN is defined.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is a flop, = !S.valid)
//   in_*                ALU result, zero flag, rd, control bits, store data,
//                       branch type and branch target
//   out_valid/out_ready downstream handshake for the head entry
//   out_*               head entry fields, driven straight from H
//   flush               discards both buffered entries
//   br_taken            one-cycle pulse after a taken branch leaves H
//   br_target           registered target PC, held between taken branches
//   fwd_valid/rd/data   (EX_MEM_FWD_EN only) bypass view of H
module ex_mem_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_zero,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_br_eq,
  input  logic              in_br_ne,
  input  logic [DATA_W-1:0] in_br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data,
  input  logic              flush,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic              zero;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] store_data;
    logic              br_eq;
    logic              br_ne;
    logic [DATA_W-1:0] br_target;
  } entry_t;

  entry_t h_q;
  entry_t s_q;
  entry_t in_e;
  logic   h_valid;
  logic   s_empty;
  logic   accept;
  logic   drain;
  logic   taken;

  // Pack the incoming fields into one entry
  always_comb begin
    in_e            = '0;
    in_e.alu_out    = in_alu_out;
    in_e.zero       = in_zero;
    in_e.rd         = in_rd;
    in_e.reg_write  = in_reg_write;
    in_e.mem_read   = in_mem_read;
    in_e.mem_write  = in_mem_write;
    in_e.store_data = in_store_data;
    in_e.br_eq      = in_br_eq;
    in_e.br_ne      = in_br_ne;
    in_e.br_target  = in_br_target;
  end

  assign in_ready = s_empty;
  assign accept   = in_valid && s_empty;
  assign drain    = h_valid && out_ready;

  // BEQ wins when both branch bits are set
  assign taken = h_q.br_eq ? h_q.zero : (h_q.br_ne && !h_q.zero);

  // Skid buffer transfers and branch resolution; rst over flush over transfers
  always_ff @(posedge clk) begin
    br_taken <= 1'b0;
    if (rst) begin
      h_valid   <= 1'b0;
      s_empty   <= 1'b1;
      h_q       <= '0;
      s_q       <= '0;
      br_target <= '0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_empty <= 1'b1;
    end else begin
      if (drain && taken) begin
        br_taken  <= 1'b1;
        br_target <= h_q.br_target;
      end
      if (drain) begin
        if (!s_empty) begin
          h_q     <= s_q;
          s_empty <= 1'b1;
        end else if (accept) begin
          h_q <= in_e;
        end else begin
          h_valid <= 1'b0;
        end
      end else if (accept) begin
        if (h_valid) begin
          s_q     <= in_e;
          s_empty <= 1'b0;
        end else begin
          h_q     <= in_e;
          h_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid      = h_valid;
  assign out_alu_out    = h_q.alu_out;
  assign out_rd         = h_q.rd;
  assign out_reg_write  = h_q.reg_write;
  assign out_mem_read   = h_q.mem_read;
  assign out_mem_write  = h_q.mem_write;
  assign out_store_data = h_q.store_data;

`ifdef EX_MEM_FWD_EN
  // Loads are not forwarded: their data is not known until the memory returns it
  assign fwd_valid = h_valid && h_q.reg_write && !h_q.mem_read && (h_q.rd != '0);
  assign fwd_rd    = h_q.rd;
  assign fwd_data  = h_q.alu_out;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a table of per-cycle vectors plus
// hand-written sequences for reset mid-transfer and forwarding.
module tb_ex_mem_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_out;
  logic              in_zero;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [DATA_W-1:0] in_store_data;
  logic              in_br_eq;
  logic              in_br_ne;
  logic [DATA_W-1:0] in_br_target;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_out;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic [DATA_W-1:0] out_store_data;
  logic              flush;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
`ifdef EX_MEM_FWD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_zero(in_zero), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_store_data(in_store_data),
    .in_br_eq(in_br_eq), .in_br_ne(in_br_ne), .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_out(out_alu_out), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .flush(flush), .br_taken(br_taken), .br_target(br_target)
`ifdef EX_MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [15:0] alu;
    logic        zero;
    logic        eq;
    logic        ne;
    logic [15:0] tgt;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_alu;
    logic        cd;
    logic        e_bt;
    logic [15:0] e_btgt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [15:0] alu,
                              logic zero, logic eq, logic ne, logic [15:0] tgt,
                              logic e_ir, logic e_ov, logic [15:0] e_alu,
                              logic cd, logic e_bt, logic [15:0] e_btgt);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.alu = alu; v.zero = zero;
    v.eq = eq; v.ne = ne; v.tgt = tgt; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_alu = e_alu; v.cd = cd; v.e_bt = e_bt; v.e_btgt = e_btgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Side fields are derived from alu so every entry carries a distinct pattern
  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [15:0] alu, input logic zero,
                       input logic eq, input logic ne, input logic [15:0] tgt);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    in_alu_out    = alu;
    in_zero       = zero;
    in_br_eq      = eq;
    in_br_ne      = ne;
    in_br_target  = tgt;
    in_rd         = alu[2:0];
    in_reg_write  = alu[0];
    in_mem_read   = alu[1];
    in_mem_write  = alu[2];
    in_store_data = alu ^ 16'hFF00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [15:0] e_alu);
    logic [15:0] e_sd;
    logic [2:0]  e_rd;
    e_sd = e_alu ^ 16'hFF00;
    e_rd = e_alu[2:0];
    chk({name, ".out_alu_out"}, 32'(out_alu_out), 32'(e_alu));
    chk({name, ".out_rd"}, 32'(out_rd), 32'(e_rd));
    chk({name, ".out_ctl"}, 32'({out_mem_write, out_mem_read, out_reg_write}), 32'(e_rd));
    chk({name, ".out_store_data"}, 32'(out_store_data), 32'(e_sd));
  endtask

  initial begin
    // streaming with no bubbles
    vecs[0]  = mk(1,1,0,16'h0001,0,0,0,16'h0000, 1,1,16'h0001,1,0,16'h0000);
    vecs[1]  = mk(1,1,0,16'h0002,0,0,0,16'h0000, 1,1,16'h0002,1,0,16'h0000);
    vecs[2]  = mk(1,1,0,16'h0003,0,0,0,16'h0000, 1,1,16'h0003,1,0,16'h0000);
    vecs[3]  = mk(1,1,0,16'h0004,0,0,0,16'h0000, 1,1,16'h0004,1,0,16'h0000);
    vecs[4]  = mk(1,1,0,16'h0005,0,0,0,16'h0000, 1,1,16'h0005,1,0,16'h0000);
    vecs[5]  = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0000);
    // backpressure fills the skid, then drains in order
    vecs[6]  = mk(1,0,0,16'h00AA,0,0,0,16'h0000, 1,1,16'h00AA,1,0,16'h0000);
    vecs[7]  = mk(1,0,0,16'h00BB,0,0,0,16'h0000, 0,1,16'h00AA,1,0,16'h0000);
    vecs[8]  = mk(0,0,0,16'h0000,0,0,0,16'h0000, 0,1,16'h00AA,1,0,16'h0000);
    vecs[9]  = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,1,16'h00BB,1,0,16'h0000);
    vecs[10] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0000);
    // BEQ taken, BEQ not taken, BNE taken, both set (BEQ wins, not taken)
    vecs[11] = mk(1,1,0,16'h0011,1,1,0,16'h0040, 1,1,16'h0011,1,0,16'h0000);
    vecs[12] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,1,16'h0040);
    vecs[13] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0040);
    vecs[14] = mk(1,1,0,16'h0012,0,1,0,16'h0080, 1,1,16'h0012,1,0,16'h0040);
    vecs[15] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0040);
    vecs[16] = mk(1,1,0,16'h0013,0,0,1,16'h0090, 1,1,16'h0013,1,0,16'h0040);
    vecs[17] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,1,16'h0090);
    vecs[18] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0090);
    vecs[19] = mk(1,1,0,16'h0014,0,1,1,16'h00A0, 1,1,16'h0014,1,0,16'h0090);
    vecs[20] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0090);
    // flush with both entries full, then flush discarding an accepted input
    vecs[21] = mk(1,0,0,16'h0021,1,1,0,16'h0050, 1,1,16'h0021,1,0,16'h0090);
    vecs[22] = mk(1,0,0,16'h0022,0,0,0,16'h0000, 0,1,16'h0021,1,0,16'h0090);
    vecs[23] = mk(1,0,1,16'h0022,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0090);
    vecs[24] = mk(1,0,1,16'h0024,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0090);
    vecs[25] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0090);
    vecs[26] = mk(1,0,0,16'h0026,0,0,0,16'h0000, 1,1,16'h0026,1,0,16'h0090);
    vecs[27] = mk(0,1,0,16'h0000,0,0,0,16'h0000, 1,0,16'h0000,0,0,16'h0090);

    // reset for two clocks then idle
    rst = 1'b1;
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.br_taken", 32'(br_taken), 32'd0);
    chk("reset.out_alu_out", 32'(out_alu_out), 32'd0);
    chk("reset.br_target", 32'(br_target), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].alu,
            vecs[i].zero, vecs[i].eq, vecs[i].ne, vecs[i].tgt);
      tick();
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d.br_taken", i), 32'(br_taken), 32'(vecs[i].e_bt));
      chk($sformatf("v%0d.br_target", i), 32'(br_target), 32'(vecs[i].e_btgt));
      if (vecs[i].cd) chk_head($sformatf("v%0d", i), vecs[i].e_alu);
    end

    // reset (with flush also high) while both entries are full
    drive(1, 0, 0, 16'h0031, 1, 1, 0, 16'h0070);
    tick();
    drive(1, 0, 0, 16'h0032, 0, 0, 0, 16'h0000);
    tick();
    chk("midrst.pre_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    drive(0, 1, 1, 16'h0000, 0, 0, 0, 16'h0000);
    tick();
    rst = 1'b0;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.out_alu_out", 32'(out_alu_out), 32'd0);
    chk("midrst.br_taken", 32'(br_taken), 32'd0);
    chk("midrst.br_target", 32'(br_target), 32'd0);
    drive(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000);
    tick();
    chk("midrst.idle_out_valid", 32'(out_valid), 32'd0);
    chk("midrst.idle_br_taken", 32'(br_taken), 32'd0);

`ifdef EX_MEM_FWD_EN
    chk("fwd.empty_valid", 32'(fwd_valid), 32'd0);
    drive(1, 0, 0, 16'h1234, 0, 0, 0, 16'h0000);
    in_rd = 3'd3; in_reg_write = 1'b1; in_mem_read = 1'b0;
    tick();
    chk("fwd.valid", 32'(fwd_valid), 32'd1);
    chk("fwd.rd", 32'(fwd_rd), 32'd3);
    chk("fwd.data", 32'(fwd_data), 32'h1234);
    drive(1, 1, 0, 16'h1234, 0, 0, 0, 16'h0000);
    in_rd = 3'd3; in_reg_write = 1'b1; in_mem_read = 1'b1;
    tick();
    chk("fwd.load_valid", 32'(fwd_valid), 32'd0);
    chk("fwd.load_out_valid", 32'(out_valid), 32'd1);
    drive(1, 1, 0, 16'h1234, 0, 0, 0, 16'h0000);
    in_rd = 3'd0; in_reg_write = 1'b1; in_mem_read = 1'b0;
    tick();
    chk("fwd.rd0_valid", 32'(fwd_valid), 32'd0);
    chk("fwd.rd0_out_valid", 32'(out_valid), 32'd1);
    drive(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
